pipeline_skid_buffer: RTL
=========================

PIPELINE_SKID_BUFFER -- requirements
Module: pipeline_skid_buffer

Interface
REQ-001 Parameter: WORD_SIZE, 32, data width in bits; its value comes from the shared parameters include.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream has a word on in_data.
REQ-005 in_data  input  WORD_SIZE  upstream word.
REQ-006 in_ready  output  1  buffer can accept a word this cycle.
REQ-007 out_valid  output  1  out_data holds a valid word.
REQ-008 out_data  output  WORD_SIZE  word presented downstream.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 flush  input  1  synchronous discard of all buffered words; present only with SKID_FLUSH_EN.

Function
REQ-011 Upstream transfer (accept): in_valid && in_ready at a rising edge; downstream transfer (issue): out_valid && out_ready at a rising edge.
REQ-012 Storage: one main register driving out_data plus one skid register; state machine EMPTY (0 words), BUSY (main valid), FULL (main + skid valid).
REQ-013 in_ready = 1 in EMPTY and BUSY, 0 in FULL; decoded from registered state only, with no combinational path from out_ready.
REQ-014 out_valid = 1 in BUSY and FULL, 0 in EMPTY; out_data = main register.
REQ-015 EMPTY: accept -> BUSY, main <= in_data; no accept -> stay.
REQ-016 BUSY: accept and issue -> BUSY, main <= in_data; accept only -> FULL, skid <= in_data; issue only -> EMPTY; neither -> stay.
REQ-017 FULL: issue -> BUSY, main <= skid; no issue -> stay; in_data ignored.
REQ-018 Latency: a word accepted at edge N is presented on out_data from edge N+1 onward; sustained throughput is one word per cycle when out_ready is held high.
REQ-019 While out_valid && !out_ready, out_data and out_valid are held stable until the issue edge.
REQ-020 Ordering: words issue in exactly the order accepted; none are dropped or duplicated except by flush or reset.
REQ-021 In EMPTY, out_data retains the last issued value (not cleared).

Reset
REQ-022 Reset assertion immediately forces state EMPTY, out_valid = 0, out_data = 0, skid = 0, without waiting for clk.
REQ-023 in_ready = 0 while reset is asserted; in_ready = 1 from the first cycle after deassertion.
REQ-024 Reset asserted mid-operation discards all buffered words.
REQ-025 No transfer occurs on any edge while reset is asserted.

Configuration
REQ-026 Macro SKID_FLUSH_EN defined: the flush port exists and has priority over all transitions.
- flush high at an edge: next state EMPTY; any word accepted or skid-buffered on that edge is discarded.
- A handshake completing on the flush edge counts as done for the external party.
- Data registers keep their values.
REQ-027 Macro SKID_FLUSH_EN undefined: no flush port and no flush logic; behaviour otherwise identical.

Verification
REQ-028 Streaming: reset, out_ready = 1, in_valid = 1 with words 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the next three cycles, in_ready constantly 1.
REQ-029 Backpressure: accept 0xA then 0xB while out_ready = 0 -> state FULL, in_ready = 0, out_data = 0xA held; raise out_ready -> 0xA then 0xB issue, in_ready returns to 1 after the first issue.
REQ-030 FULL with in_valid = 1 and in_data = 0xDEAD, out_ready = 0 for 5 cycles -> 0xDEAD never accepted, out_data stays stable.
REQ-031 Async reset asserted between edges while FULL -> out_valid = 0 and out_data = 0 immediately; after release, in_ready = 1 and no stale words issue.
REQ-032 With SKID_FLUSH_EN defined: FULL holding 0x5,0x6, flush = 1 for one edge -> out_valid = 0 next cycle, in_ready = 1, neither word issues.
REQ-033 Random valid/ready stress over 10,000 cycles -> scoreboard shows in-order, lossless transfer and no X on outputs after reset.

Source files
------------

// File: rtl/pipeline_skid_buffer.sv
// Two-entry pipeline skid buffer: a main register drives out_data and a skid
// register catches the word accepted while downstream stalls. in_ready comes
// only from registered state, so out_ready has no combinational path to it.
// Optional feature: define SKID_FLUSH_EN to add a synchronous flush port that
// empties the buffer and overrides every other transition.

package skid_params_pkg;
    parameter int WORD_SIZE = 32;
endpackage

module pipeline_skid_buffer #(
    parameter int WORD_SIZE = skid_params_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef SKID_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] out_data,
    input  logic                 out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] main_q, main_d;
    logic [WORD_SIZE-1:0] skid_q, skid_d;
    logic                 accept, issue;

    // Handshake decode; in_ready is held low for the whole reset assertion.
    assign in_ready  = (state_q != FULL) && !reset;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign issue     = out_valid && out_ready;

    // Next-state and data-path selection; registers hold unless a move is due.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = BUSY;
                    main_d  = in_data;
                end
            end
            BUSY: begin
                if (accept && issue) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (issue) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so in_data is never looked at.
                if (issue) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
`ifdef SKID_FLUSH_EN
        // Flush drops everything in flight but leaves data registers as-is,
        // so out_data keeps showing the last main word while empty.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
`endif
    end

    // State and data registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
